// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller:
// state enum, opcode/funct values, mux select encodings and ALU function codes.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    ADDIEX,
    ADDIWB,
    JEX
  } mc_state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic isSupportedOp(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
           (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's aluop and the instruction funct field
// onto the 3-bit ALU function code.
module mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  // aluop 11 is never produced by the FSM and falls back to add
  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALU_ADD;
          FN_SUB:  o_alucontrol = ALU_SUB;
          FN_AND:  o_alucontrol = ALU_AND;
          FN_OR:   o_alucontrol = ALU_OR;
          FN_SLT:  o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore main controller for the multicycle MIPS: sequences each instruction
// through FETCH/DECODE/execute states and counts retired instructions.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [2:0]       alucontrol,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  mc_state_t        r_state;
  mc_state_t        w_nextState;
  logic [CNT_W-1:0] r_instret;
  logic             w_pcwrite;
  logic             w_branch;
  logic [1:0]       w_aluop;
  logic             w_opLegal;
  logic             w_retire;

  assign w_opLegal = isSupportedOp(op);

  // Terminal states always return to FETCH, which is when an instruction retires
  assign w_retire = (r_state == MEMWB)   || (r_state == MEMWR)  ||
                    (r_state == RTYPEWB) || (r_state == ADDIWB) ||
                    (r_state == BEQEX)   || (r_state == JEX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = FETCH;
    case (r_state)
      FETCH: w_nextState = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_nextState = MEMADR;
          OP_RTYPE:     w_nextState = RTYPEEX;
          OP_BEQ:       w_nextState = BEQEX;
          OP_ADDI:      w_nextState = ADDIEX;
          OP_J:         w_nextState = JEX;
          default:      w_nextState = FETCH;
        endcase
      end
      MEMADR:  w_nextState = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   w_nextState = MEMWB;
      RTYPEEX: w_nextState = RTYPEWB;
      ADDIEX:  w_nextState = ADDIWB;
      default: w_nextState = FETCH;
    endcase
  end

  // Reset overrides the decoded outputs so nothing is written while held
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALU;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_aluop    = ALUOP_ADD;
    illegal_op = 1'b0;
    case (r_state)
      FETCH: begin
        irwrite   = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = SRCB_FOUR;
      end
      DECODE: begin
        alusrcb    = SRCB_IMMSH;
        illegal_op = ~w_opLegal;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        w_branch = 1'b1;
      end
      JEX: begin
        pcsrc     = PCSRC_JUMP;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_FOUR;
      pcsrc      = PCSRC_ALU;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_aluop    = ALUOP_ADD;
      illegal_op = 1'b0;
    end
    pcen = w_pcwrite | (w_branch & zero);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = r_instret;

  mc_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: a cycle-level reference model
// queues the expected control vector and instret for every cycle.
module tb_mips_mc_controller;
  import mips_mc_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]       alusrcb, pcsrc;
  logic             pcen;
  logic [2:0]       alucontrol;
  logic             illegal_op;
  logic [CNT_W-1:0] instret;

  typedef struct packed {
    logic [15:0]      ctrl;
    logic [CNT_W-1:0] cnt;
  } expect_t;

  expect_t          sb[$];
  string            tagQ[$];
  int               checks = 0;
  int               failures = 0;
  mc_state_t        mState;
  logic [CNT_W-1:0] mInstret;
  logic [5:0]       opTab[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b001000, 6'b000010, 6'b011111};
  logic [5:0]       fnTab[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b101010, 6'b000011};

  mips_mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
    .illegal_op(illegal_op), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] refAlu(input logic [1:0] aluop, input logic [5:0] f);
    if (aluop == 2'b01) return 3'b110;
    if (aluop != 2'b10) return 3'b010;
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Vector order: iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc pcen alucontrol illegal_op
  function automatic logic [15:0] expectCtrl(input mc_state_t s, input logic [5:0] o,
                                             input logic [5:0] f, input logic z, input logic rst);
    logic eIord = 0, eMw = 0, eIrw = 0, eDst = 0, eMtr = 0, eRw = 0, eSa = 0;
    logic [1:0] eSb = 2'b00, ePc = 2'b00, eOp = 2'b00;
    logic ePcw = 0, eBr = 0, eIll = 0;
    if (rst) begin
      eSb = 2'b01;
    end else begin
      case (s)
        FETCH:   begin eIrw = 1; ePcw = 1; eSb = 2'b01; end
        DECODE:  begin
          eSb = 2'b11;
          eIll = !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        end
        MEMADR, ADDIEX: begin eSa = 1; eSb = 2'b10; end
        MEMRD:   eIord = 1;
        MEMWB:   begin eMtr = 1; eRw = 1; end
        MEMWR:   begin eIord = 1; eMw = 1; end
        RTYPEEX: begin eSa = 1; eOp = 2'b10; end
        RTYPEWB: begin eDst = 1; eRw = 1; end
        ADDIWB:  eRw = 1;
        BEQEX:   begin eSa = 1; eOp = 2'b01; ePc = 2'b01; eBr = 1; end
        JEX:     begin ePc = 2'b10; ePcw = 1; end
        default: ;
      endcase
    end
    return {eIord, eMw, eIrw, eDst, eMtr, eRw, eSa, eSb, ePc, ePcw | (eBr & z),
            refAlu(eOp, f), eIll};
  endfunction

  function automatic mc_state_t refNext(input mc_state_t s, input logic [5:0] o);
    case (s)
      FETCH: return DECODE;
      DECODE: begin
        if (o == 6'b100011 || o == 6'b101011) return MEMADR;
        if (o == 6'b000000) return RTYPEEX;
        if (o == 6'b000100) return BEQEX;
        if (o == 6'b001000) return ADDIEX;
        if (o == 6'b000010) return JEX;
        return FETCH;
      end
      MEMADR:  return (o == 6'b101011) ? MEMWR : MEMRD;
      MEMRD:   return MEMWB;
      RTYPEEX: return RTYPEWB;
      ADDIEX:  return ADDIWB;
      default: return FETCH;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, queue the model's expectation, compare at negedge
  task automatic applyStimulus(input logic rst, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input string tag);
    expect_t e;
    string   t;
    logic [15:0] obs;
    reset = rst;
    op    = o;
    funct = f;
    zero  = z;
    sb.push_back({expectCtrl(mState, o, f, z, rst), mInstret});
    tagQ.push_back(tag);
    @(negedge clk);
    e = sb.pop_front();
    t = tagQ.pop_front();
    obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
           pcsrc, pcen, alucontrol, illegal_op};
    checkOutput({t, ".ctrl"}, 32'(obs), 32'(e.ctrl));
    checkOutput({t, ".instret"}, 32'(instret), 32'(e.cnt));
    @(posedge clk);
    if (rst) begin
      mState   = FETCH;
      mInstret = '0;
    end else begin
      if (mState inside {MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX}) mInstret = mInstret + 1'b1;
      mState = refNext(mState, o);
    end
    #1;
  endtask

  task automatic runInstr(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
    int n = 0;
    do begin
      applyStimulus(1'b0, o, f, z, $sformatf("%s.c%0d", name, n));
      n++;
    end while (mState != FETCH && n < 8);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; op = 6'b100011; funct = '0; zero = 1'b0;
    mState = FETCH; mInstret = '0;
    applyStimulus(1'b1, 6'b100011, 6'b0, 1'b0, "rst0");
    applyStimulus(1'b1, 6'b100011, 6'b0, 1'b0, "rst1");
    runInstr("lw",     6'b100011, 6'b000000, 1'b0);
    runInstr("sw",     6'b101011, 6'b000000, 1'b0);
    runInstr("slt",    6'b000000, 6'b101010, 1'b0);
    runInstr("and",    6'b000000, 6'b100100, 1'b0);
    runInstr("beqT",   6'b000100, 6'b000000, 1'b1);
    runInstr("beqF",   6'b000100, 6'b000000, 1'b0);
    runInstr("j",      6'b000010, 6'b000000, 1'b0);
    runInstr("ill",    6'b111111, 6'b000000, 1'b0);
    runInstr("addi",   6'b001000, 6'b100101, 1'b1);
    runInstr("rtDef",  6'b000000, 6'b000111, 1'b0);
    runInstr("or",     6'b000000, 6'b100101, 1'b0);
    runInstr("sub",    6'b000000, 6'b100010, 1'b1);
    // Abort a lw in MEMRD, then confirm counting restarts from zero
    applyStimulus(1'b0, 6'b100011, 6'b0, 1'b0, "abort.fetch");
    applyStimulus(1'b0, 6'b100011, 6'b0, 1'b0, "abort.decode");
    applyStimulus(1'b0, 6'b100011, 6'b0, 1'b0, "abort.memadr");
    applyStimulus(1'b1, 6'b100011, 6'b0, 1'b0, "abort.memrd");
    runInstr("postAbort", 6'b001000, 6'b000000, 1'b0);
    for (int i = 0; i < 24; i++) begin
      runInstr($sformatf("rnd%0d", i), opTab[$urandom_range(0, 6)],
               fnTab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 6'b000010, 6'b0, 1'b0, "final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
